fu_result_buffer: RTL and testbench

- Holding stage directly upstream of the two-way FU result selector.
- Holds one completed result per functional unit (ALU/LS/MULT/BEQ, FU_SIZE slots) until the selector grants it.
- Presents per-FU result-valid bits to the selector and registers the two granted results onto CDB lanes 0 and 1.
- Back-pressures each FU through a per-FU ready bit. Flushes on branch-mispredict squash.

---
 rtl/fu_result_buffer_if.sv | 45 ++++
 rtl/fu_result_buffer.sv | 135 +++++++++++++
 tb/tb_fu_result_buffer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fu_result_buffer_if.sv
// Bundle of the FU-side, selector-side and CDB-side signals of the FU result buffer.
// The master modport is the environment (FUs, selector, CDB consumers); the slave is the buffer.
interface fu_result_buffer_if #(
  parameter int unsigned FU_SIZE = 20,
  parameter int unsigned FU_CAT  = 4,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned XLEN    = 32
);
  logic [FU_SIZE-1:0]       fu_done;
  logic [FU_SIZE*TAG_W-1:0] fu_tag;
  logic [FU_SIZE*XLEN-1:0]  fu_value;
  logic [FU_SIZE-1:0]       fu_take_branch;
  logic [FU_SIZE-1:0]       fu_ready;
  logic [FU_SIZE-1:0]       fu_result_valid;

  logic [4:0]               fu_num_0;
  logic [4:0]               fu_num_1;
  logic [FU_CAT-1:0]        cat_select_0;
  logic [FU_CAT-1:0]        cat_select_1;

  logic                     cdb_valid_0;
  logic                     cdb_valid_1;
  logic [TAG_W-1:0]         cdb_tag_0;
  logic [TAG_W-1:0]         cdb_tag_1;
  logic [XLEN-1:0]          cdb_value_0;
  logic [XLEN-1:0]          cdb_value_1;
  logic                     cdb_take_branch_0;
  logic                     cdb_take_branch_1;

  modport master (
    output fu_done, fu_tag, fu_value, fu_take_branch,
    output fu_num_0, fu_num_1, cat_select_0, cat_select_1,
    input  fu_ready, fu_result_valid,
    input  cdb_valid_0, cdb_valid_1, cdb_tag_0, cdb_tag_1,
    input  cdb_value_0, cdb_value_1, cdb_take_branch_0, cdb_take_branch_1
  );

  modport slave (
    input  fu_done, fu_tag, fu_value, fu_take_branch,
    input  fu_num_0, fu_num_1, cat_select_0, cat_select_1,
    output fu_ready, fu_result_valid,
    output cdb_valid_0, cdb_valid_1, cdb_tag_0, cdb_tag_1,
    output cdb_value_0, cdb_value_1, cdb_take_branch_0, cdb_take_branch_1
  );
endinterface

// File: rtl/fu_result_buffer.sv
// One-entry-per-FU result holding stage in front of the two-way result selector.
// Granted entries are registered onto CDB lanes 0/1 one cycle later; squash empties every slot.
module fu_result_buffer #(
  parameter int unsigned FU_SIZE = 20,
  parameter int unsigned FU_CAT  = 4,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned XLEN    = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic squash,
  fu_result_buffer_if.slave bus
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       slot_state [FU_SIZE];
  logic [TAG_W-1:0] slot_tag   [FU_SIZE];
  logic [XLEN-1:0]  slot_value [FU_SIZE];
  logic             slot_tb    [FU_SIZE];

  logic [FU_SIZE-1:0] full;
  logic [FU_SIZE-1:0] sel_0, sel_1;
  logic [FU_SIZE-1:0] take_0, take_1, granted;
  logic [FU_SIZE-1:0] ready, load;
  logic               g0, g1, eff_0, eff_1;

  logic [TAG_W-1:0]   mux_tag_0, mux_tag_1;
  logic [XLEN-1:0]    mux_value_0, mux_value_1;
  logic               mux_tb_0, mux_tb_1;

  assign g0 = |bus.cat_select_0;
  assign g1 = |bus.cat_select_1;

  // Decoding fu_num against each slot index makes out-of-range numbers select nothing.
  always_comb begin
    full  = '0;
    sel_0 = '0;
    sel_1 = '0;
    for (int unsigned i = 0; i < FU_SIZE; i++) begin
      full[i]  = (slot_state[i] == FULL);
      sel_0[i] = (bus.fu_num_0 == 5'(i));
      sel_1[i] = (bus.fu_num_1 == 5'(i));
    end
  end

  // Lane 1 yields whenever lane 0 is granted the same slot.
  assign take_0  = {FU_SIZE{g0}} & sel_0 & full;
  assign take_1  = {FU_SIZE{g1}} & sel_1 & full & ~({FU_SIZE{g0}} & sel_0);
  assign granted = take_0 | take_1;
  assign eff_0   = |take_0;
  assign eff_1   = |take_1;

  assign ready = (reset || squash) ? '1 : (~full | granted);
  assign load  = bus.fu_done & ready;

  assign bus.fu_ready        = ready;
  assign bus.fu_result_valid = full;

  always_comb begin
    mux_tag_0   = '0;
    mux_tag_1   = '0;
    mux_value_0 = '0;
    mux_value_1 = '0;
    mux_tb_0    = 1'b0;
    mux_tb_1    = 1'b0;
    for (int unsigned i = 0; i < FU_SIZE; i++) begin
      if (take_0[i]) begin
        mux_tag_0   = slot_tag[i];
        mux_value_0 = slot_value[i];
        mux_tb_0    = slot_tb[i];
      end
      if (take_1[i]) begin
        mux_tag_1   = slot_tag[i];
        mux_value_1 = slot_value[i];
        mux_tb_1    = slot_tb[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < FU_SIZE; i++) begin
        slot_state[i] <= EMPTY;
        slot_tag[i]   <= '0;
        slot_value[i] <= '0;
        slot_tb[i]    <= 1'b0;
      end
    end else if (squash) begin
      for (int unsigned i = 0; i < FU_SIZE; i++) begin
        slot_state[i] <= EMPTY;
      end
    end else begin
      for (int unsigned i = 0; i < FU_SIZE; i++) begin
        if (load[i]) begin
          slot_state[i] <= FULL;
          slot_tag[i]   <= bus.fu_tag[i*TAG_W +: TAG_W];
          slot_value[i] <= bus.fu_value[i*XLEN +: XLEN];
          slot_tb[i]    <= bus.fu_take_branch[i];
        end else if (granted[i]) begin
          slot_state[i] <= EMPTY;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.cdb_valid_0       <= 1'b0;
      bus.cdb_valid_1       <= 1'b0;
      bus.cdb_tag_0         <= '0;
      bus.cdb_tag_1         <= '0;
      bus.cdb_value_0       <= '0;
      bus.cdb_value_1       <= '0;
      bus.cdb_take_branch_0 <= 1'b0;
      bus.cdb_take_branch_1 <= 1'b0;
    end else if (squash) begin
      bus.cdb_valid_0 <= 1'b0;
      bus.cdb_valid_1 <= 1'b0;
    end else begin
      bus.cdb_valid_0 <= eff_0;
      bus.cdb_valid_1 <= eff_1;
      if (eff_0) begin
        bus.cdb_tag_0         <= mux_tag_0;
        bus.cdb_value_0       <= mux_value_0;
        bus.cdb_take_branch_0 <= mux_tb_0;
      end
      if (eff_1) begin
        bus.cdb_tag_1         <= mux_tag_1;
        bus.cdb_value_1       <= mux_value_1;
        bus.cdb_take_branch_1 <= mux_tb_1;
      end
    end
  end
endmodule

// File: tb/tb_fu_result_buffer.sv
// Directed-vector bench for fu_result_buffer with hand-computed expectations.
module tb_fu_result_buffer;
  localparam int unsigned FU_SIZE = 20;
  localparam int unsigned FU_CAT  = 4;
  localparam int unsigned TAG_W   = 6;
  localparam int unsigned XLEN    = 32;

  logic clock = 1'b0;
  logic reset;
  logic squash;
  int   n_tests = 0;
  int   n_fail  = 0;

  fu_result_buffer_if #(.FU_SIZE(FU_SIZE), .FU_CAT(FU_CAT), .TAG_W(TAG_W), .XLEN(XLEN)) bus ();

  fu_result_buffer #(.FU_SIZE(FU_SIZE), .FU_CAT(FU_CAT), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clock  (clock),
    .reset  (reset),
    .squash (squash),
    .bus    (bus.slave)
  );

  always #5 clock = ~clock;

  // Writing a non-ready slot is a protocol error; the stimulus never does it.
  always @(posedge clock) begin
    if (!reset && ((bus.fu_done & ~bus.fu_ready) != '0))
      $error("protocol: fu_done to non-ready slot %h", bus.fu_done & ~bus.fu_ready);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.fu_done        = '0;
    bus.fu_tag         = '0;
    bus.fu_value       = '0;
    bus.fu_take_branch = '0;
    bus.fu_num_0       = '0;
    bus.fu_num_1       = '0;
    bus.cat_select_0   = '0;
    bus.cat_select_1   = '0;
    squash             = 1'b0;
  endtask

  task automatic put(input int unsigned slot, input logic [TAG_W-1:0] tag,
                     input logic [XLEN-1:0] val, input logic tb);
    bus.fu_done[slot]                  = 1'b1;
    bus.fu_tag[slot*TAG_W +: TAG_W]    = tag;
    bus.fu_value[slot*XLEN +: XLEN]    = val;
    bus.fu_take_branch[slot]           = tb;
  endtask

  task automatic grant0(input logic [4:0] n, input logic [FU_CAT-1:0] cat);
    bus.fu_num_0     = n;
    bus.cat_select_0 = cat;
  endtask

  task automatic grant1(input logic [4:0] n, input logic [FU_CAT-1:0] cat);
    bus.fu_num_1     = n;
    bus.cat_select_1 = cat;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    check("rst_rv",     64'(bus.fu_result_valid), 64'h0);
    check("rst_ready",  64'(bus.fu_ready), 64'hFFFFF);
    check("rst_cv0",    64'(bus.cdb_valid_0), 64'h0);
    check("rst_cv1",    64'(bus.cdb_valid_1), 64'h0);
    check("rst_tag0",   64'(bus.cdb_tag_0), 64'h0);

    // Single result through lane 0
    put(0, 6'd5, 32'hDEAD, 1'b0);
    step();
    idle();
    check("s0_rv_before", 64'(bus.fu_result_valid), 64'h1);
    check("s0_ready_full", 64'(bus.fu_ready[0]), 64'h0);
    grant0(5'd0, 4'b0001);
    #1;
    check("s0_ready_granted", 64'(bus.fu_ready[0]), 64'h1);
    step();
    idle();
    check("s0_cv0",   64'(bus.cdb_valid_0), 64'h1);
    check("s0_tag0",  64'(bus.cdb_tag_0), 64'd5);
    check("s0_val0",  64'(bus.cdb_value_0), 64'hDEAD);
    check("s0_cv1",   64'(bus.cdb_valid_1), 64'h0);
    check("s0_rv_after", 64'(bus.fu_result_valid), 64'h0);
    step();
    check("s0_cv0_drop", 64'(bus.cdb_valid_0), 64'h0);
    check("s0_tag0_hold", 64'(bus.cdb_tag_0), 64'd5);

    // Dual broadcast, slots 17 and 16
    put(17, 6'd17, 32'h1111, 1'b1);
    put(16, 6'd16, 32'h2222, 1'b0);
    step();
    idle();
    check("dual_rv", 64'(bus.fu_result_valid), 64'h30000);
    grant0(5'd17, 4'b0010);
    grant1(5'd16, 4'b0100);
    step();
    idle();
    check("dual_cv0", 64'(bus.cdb_valid_0), 64'h1);
    check("dual_cv1", 64'(bus.cdb_valid_1), 64'h1);
    check("dual_tb0", 64'(bus.cdb_take_branch_0), 64'h1);
    check("dual_tb1", 64'(bus.cdb_take_branch_1), 64'h0);
    check("dual_tag0", 64'(bus.cdb_tag_0), 64'd17);
    check("dual_tag1", 64'(bus.cdb_tag_1), 64'd16);
    check("dual_val1", 64'(bus.cdb_value_1), 64'h2222);
    check("dual_rv_after", 64'(bus.fu_result_valid), 64'h0);

    // Slot 4 held, then grant + refill in the same cycle
    put(4, 6'd3, 32'h44, 1'b0);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      check("hold_ready4", 64'(bus.fu_ready[4]), 64'h0);
      check("hold_rv4",    64'(bus.fu_result_valid[4]), 64'h1);
      step();
    end
    grant0(5'd4, 4'b1000);
    put(4, 6'd9, 32'h99, 1'b1);
    #1;
    check("refill_ready4", 64'(bus.fu_ready[4]), 64'h1);
    step();
    idle();
    check("refill_cv0",  64'(bus.cdb_valid_0), 64'h1);
    check("refill_tag0", 64'(bus.cdb_tag_0), 64'd3);
    check("refill_val0", 64'(bus.cdb_value_0), 64'h44);
    check("refill_rv4",  64'(bus.fu_result_valid[4]), 64'h1);
    grant1(5'd4, 4'b0001);
    step();
    idle();
    check("refill_cv1",  64'(bus.cdb_valid_1), 64'h1);
    check("refill_tag1", 64'(bus.cdb_tag_1), 64'd9);
    check("refill_val1", 64'(bus.cdb_value_1), 64'h99);
    check("refill_tb1",  64'(bus.cdb_take_branch_1), 64'h1);
    check("refill_rv_empty", 64'(bus.fu_result_valid), 64'h0);

    // Squash overrides grant and fu_done
    put(0, 6'd10, 32'hA0, 1'b0);
    put(9, 6'd11, 32'hA9, 1'b0);
    put(12, 6'd12, 32'hAC, 1'b0);
    step();
    idle();
    check("sq_rv_before", 64'(bus.fu_result_valid), 64'h1201);
    squash = 1'b1;
    grant0(5'd0, 4'b0001);
    put(3, 6'd1, 32'h33, 1'b0);
    #1;
    check("sq_ready", 64'(bus.fu_ready), 64'hFFFFF);
    step();
    idle();
    check("sq_rv",  64'(bus.fu_result_valid), 64'h0);
    check("sq_cv0", 64'(bus.cdb_valid_0), 64'h0);
    check("sq_tag0_hold", 64'(bus.cdb_tag_0), 64'd3);
    step();
    check("sq_slot3", 64'(bus.fu_result_valid[3]), 64'h0);

    // Grant of an empty slot, then both lanes on one slot
    grant1(5'd7, 4'b0010);
    step();
    idle();
    check("empty_cv1", 64'(bus.cdb_valid_1), 64'h0);
    check("empty_cv0", 64'(bus.cdb_valid_0), 64'h0);
    put(2, 6'd2, 32'h222, 1'b0);
    step();
    idle();
    grant0(5'd2, 4'b0001);
    grant1(5'd2, 4'b0001);
    step();
    idle();
    check("same_cv0",  64'(bus.cdb_valid_0), 64'h1);
    check("same_tag0", 64'(bus.cdb_tag_0), 64'd2);
    check("same_cv1",  64'(bus.cdb_valid_1), 64'h0);
    check("same_rv2",  64'(bus.fu_result_valid[2]), 64'h0);
    step();
    check("same_once", 64'(bus.cdb_valid_0), 64'h0);

    // Out-of-range fu_num ignored; highest slot 19 still reachable
    put(19, 6'd63, 32'hFFFF_FFFF, 1'b1);
    step();
    idle();
    grant0(5'd25, 4'b0001);
    grant1(5'd20, 4'b0001);
    step();
    idle();
    check("oor_cv0",  64'(bus.cdb_valid_0), 64'h0);
    check("oor_cv1",  64'(bus.cdb_valid_1), 64'h0);
    check("oor_rv19", 64'(bus.fu_result_valid), 64'h80000);
    grant1(5'd19, 4'b1000);
    step();
    idle();
    check("s19_cv1",  64'(bus.cdb_valid_1), 64'h1);
    check("s19_tag1", 64'(bus.cdb_tag_1), 64'd63);
    check("s19_val1", 64'(bus.cdb_value_1), 64'hFFFF_FFFF);

    // Reset mid-operation discards the in-flight grant
    put(5, 6'd21, 32'h55, 1'b0);
    step();
    idle();
    reset = 1'b1;
    squash = 1'b1;
    grant0(5'd5, 4'b0001);
    step();
    idle();
    reset = 1'b0;
    check("mrst_cv0",  64'(bus.cdb_valid_0), 64'h0);
    check("mrst_tag0", 64'(bus.cdb_tag_0), 64'h0);
    check("mrst_tag1", 64'(bus.cdb_tag_1), 64'h0);
    check("mrst_rv",   64'(bus.fu_result_valid), 64'h0);
    check("mrst_ready", 64'(bus.fu_ready), 64'hFFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
